tune_decoder: RTL and testbench

TUNE_DECODER -- requirements
Module: tune_decoder

---
 rtl/tune_decoder.sv | 195 +++++++++++++++++++
 tb/tb_tune_decoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tune_decoder.sv
// tune_decoder
// ------------
// Measures the period of an asynchronous square-wave tone and classifies it
// against a fixed table of fourteen nominal note periods. A note is reported
// on tune_code only after MATCH_CNT consecutive periods classify to the same
// code. If no rising edge arrives for TIMEOUT cycles, the tone is declared
// silent.
//
// Parameters
//   MATCH_CNT  consecutive same-code periods needed before tune_code updates (1..3)
//   TIMEOUT    clk cycles without a rising edge before silence is declared
//
// Ports
//   clk          system clock; all logic uses its rising edge
//   nRST         asynchronous active-low reset
//   en           decoder enable; low forces IDLE and holds tune_code/period
//   wave_in      asynchronous square-wave input
//   tune_code    decoded tone: 0 = silence, 1..14 = notes
//   code_valid   registered (tune_code != 0)
//   code_strobe  one-cycle pulse on every tune_code change
//   period       last measured full period in clk cycles
//   bad_period   one-cycle pulse when a period matches no table entry
//   dbg_state    FSM state: 0 = IDLE, 1 = MEASURE
//
// Output semantics: code_valid is a level qualifier for tune_code, not a
// handshake. code_strobe and bad_period are single-cycle event pulses with no
// back-pressure; a consumer must sample them on every clock.
module tune_decoder #(
  parameter int unsigned MATCH_CNT = 2,
  parameter logic [15:0] TIMEOUT   = 16'd32767
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        en,
  input  logic        wave_in,
  output logic [3:0]  tune_code,
  output logic        code_valid,
  output logic        code_strobe,
  output logic [15:0] period,
  output logic        bad_period,
  output logic        dbg_state
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [1:0] MATCH_TGT = 2'(MATCH_CNT);

  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic        sync_prev_q;
  logic        rise;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic [1:0]  mc_q, mc_d, mc_inc;
  logic [3:0]  match_code;
  logic [3:0]  code_d;
  logic        valid_d, strobe_d, bad_d;
  logic [15:0] period_d;

  // Nominal full period for each note code.
  function automatic logic [15:0] nominal(input logic [3:0] code);
    case (code)
      4'd1:    return 16'd22934;
      4'd2:    return 16'd20431;
      4'd3:    return 16'd18202;
      4'd4:    return 16'd17181;
      4'd5:    return 16'd15306;
      4'd6:    return 16'd13636;
      4'd7:    return 16'd12149;
      4'd8:    return 16'd11467;
      4'd9:    return 16'd10216;
      4'd10:   return 16'd9101;
      4'd11:   return 16'd8590;
      4'd12:   return 16'd7653;
      4'd13:   return 16'd6818;
      4'd14:   return 16'd6074;
      default: return 16'd0;
    endcase
  endfunction

  // Tolerance window is +/- nom/64 (about 1.6 %), inclusive at both ends.
  function automatic logic in_window(input logic [15:0] p, input logic [15:0] nom);
    logic [15:0] tol;
    tol = nom >> 6;
    return (p >= (nom - tol)) && (p <= (nom + tol));
  endfunction

  // Rising edge on the synchronized input.
  assign rise      = sync_q[1] & ~sync_prev_q;
  assign dbg_state = state_q;

  // Classifier on the live counter value. Scanning from the top down lets the
  // lowest matching code overwrite any higher one.
  always_comb begin
    match_code = 4'd0;
    for (int k = 14; k >= 1; k--) begin
      if (in_window(cnt_q, nominal(4'(k)))) match_code = 4'(k);
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    mc_d     = mc_q;
    code_d   = tune_code;
    strobe_d = 1'b0;
    bad_d    = 1'b0;
    period_d = period;
    mc_inc   = (mc_q == 2'd3) ? 2'd3 : mc_q + 2'd1;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = 16'd0;
      mc_d    = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = 16'd0;
          // First edge only starts the count; there is no period to report.
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = 16'd1;
          end
        end
        MEASURE: begin
          // An edge wins over a simultaneous timeout.
          if (rise) begin
            period_d = cnt_q;
            cnt_d    = 16'd1;
            if (match_code == 4'd0) begin
              bad_d = 1'b1;
              mc_d  = 2'd0;
            end else begin
              if (match_code == cand_q) begin
                mc_d = mc_inc;
              end else begin
                cand_d = match_code;
                mc_d   = 2'd1;
              end
              if ((mc_d >= MATCH_TGT) && (match_code != tune_code)) begin
                code_d   = match_code;
                strobe_d = 1'b1;
              end
            end
          end else if (cnt_q >= TIMEOUT) begin
            state_d  = IDLE;
            cnt_d    = 16'd0;
            mc_d     = 2'd0;
            code_d   = 4'd0;
            strobe_d = (tune_code != 4'd0);
          end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    valid_d = (code_d != 4'd0);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sync_q      <= 2'b00;
      sync_prev_q <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      cand_q      <= 4'd0;
      mc_q        <= 2'd0;
      tune_code   <= 4'd0;
      code_valid  <= 1'b0;
      code_strobe <= 1'b0;
      bad_period  <= 1'b0;
      period      <= 16'd0;
    end else begin
      sync_q      <= {sync_q[0], wave_in};
      sync_prev_q <= sync_q[1];
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      mc_q        <= mc_d;
      tune_code   <= code_d;
      code_valid  <= valid_d;
      code_strobe <= strobe_d;
      bad_period  <= bad_d;
      period      <= period_d;
    end
  end

endmodule

// File: tb/tb_tune_decoder.sv
// Bench for tune_decoder. Uses the short-period notes (codes 13 and 14) and a
// reduced TIMEOUT so every scenario fits in a modest number of cycles.
module tb_tune_decoder;

  localparam int unsigned TIMEOUT_CYC = 7000;

  // Clock / reset
  logic        clk = 1'b0;
  logic        nRST;
  logic        en;
  logic        wave_in;
  logic [3:0]  tune_code;
  logic        code_valid;
  logic        code_strobe;
  logic [15:0] period;
  logic        bad_period;
  logic        dbg_state;

  always #5 clk = ~clk;

  tune_decoder #(
    .MATCH_CNT (2),
    .TIMEOUT   (16'(TIMEOUT_CYC))
  ) dut (
    .clk         (clk),
    .nRST        (nRST),
    .en          (en),
    .wave_in     (wave_in),
    .tune_code   (tune_code),
    .code_valid  (code_valid),
    .code_strobe (code_strobe),
    .period      (period),
    .bad_period  (bad_period),
    .dbg_state   (dbg_state)
  );

  // Vector table: period ending at a rising edge, and what must follow it.
  typedef struct {
    int unsigned p;
    logic [3:0]  code;
    logic        bad;
    logic        strobe;
  } vec_t;

  vec_t vecs [9];

  // Scoreboard: expected code at each strobe, expected period at each bad pulse.
  logic [3:0]  exp_code_q [$];
  logic [15:0] exp_bad_q  [$];

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance n falling edges; any strobe or bad pulse seen is matched against
  // the scoreboard.
  task automatic tick(input int n);
    logic [3:0]  ec;
    logic [15:0] eb;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (code_strobe) begin
        if (exp_code_q.size() == 0) check("unexpected_strobe", code_strobe, 0);
        else begin
          ec = exp_code_q.pop_front();
          check("strobe_code", tune_code, ec);
        end
      end
      if (bad_period) begin
        if (exp_bad_q.size() == 0) check("unexpected_bad", bad_period, 0);
        else begin
          eb = exp_bad_q.pop_front();
          check("bad_period_value", period, eb);
        end
      end
    end
  endtask

  // wave_in is high and rose 3 falling edges ago; produce the next rising
  // edge exactly p cycles after the previous one.
  task automatic edge_after(input int p);
    tick(p / 2 - 3);
    wave_in = 1'b0;
    tick(p - p / 2);
    wave_in = 1'b1;
  endtask

  // Outputs must be unchanged two falling edges after the rise and updated
  // on the third (2 sync flops, detect, register).
  task automatic check_window(input string tag, input logic [3:0] pre_code,
                              input logic [3:0] code, input logic bad,
                              input logic strobe, input logic [15:0] per);
    tick(2);
    check({tag, "_pre_strobe"}, code_strobe, 0);
    check({tag, "_pre_code"}, tune_code, pre_code);
    tick(1);
    check({tag, "_code"}, tune_code, code);
    check({tag, "_valid"}, code_valid, (code != 4'd0));
    check({tag, "_strobe"}, code_strobe, strobe);
    check({tag, "_bad"}, bad_period, bad);
    check({tag, "_period"}, period, per);
    check({tag, "_state"}, dbg_state, 1);
  endtask

  initial begin
    logic [3:0] cur_code;

    // code 14: N=6074, tol=94 -> 5980..6168; code 13: N=6818, tol=106
    vecs[0] = '{6818, 4'd0,  1'b0, 1'b0};  // candidate 13, count 1
    vecs[1] = '{6818, 4'd13, 1'b0, 1'b1};  // 3rd edge decodes 13
    vecs[2] = '{6074, 4'd13, 1'b0, 1'b0};  // new candidate 14
    vecs[3] = '{6074, 4'd14, 1'b0, 1'b1};  // switch to 14
    vecs[4] = '{6169, 4'd14, 1'b1, 1'b0};  // one above window
    vecs[5] = '{5979, 4'd14, 1'b1, 1'b0};  // one below window
    vecs[6] = '{5980, 4'd14, 1'b0, 1'b0};  // lower edge matches, count 1
    vecs[7] = '{6168, 4'd14, 1'b0, 1'b0};  // upper edge, count 2, equals code
    vecs[8] = '{6818, 4'd14, 1'b0, 1'b0};  // alternate to 13, count 1

    nRST    = 1'b0;
    en      = 1'b1;
    wave_in = 1'b0;
    tick(3);
    check("rst_code", tune_code, 0);
    check("rst_valid", code_valid, 0);
    check("rst_strobe", code_strobe, 0);
    check("rst_bad", bad_period, 0);
    check("rst_period", period, 0);
    check("rst_state", dbg_state, 0);

    nRST = 1'b1;
    tick(5);
    check("idle_state", dbg_state, 0);

    // First edge only starts the measurement.
    wave_in = 1'b1;
    tick(2);
    check("start_pre_state", dbg_state, 0);
    tick(1);
    check("start_state", dbg_state, 1);
    check("start_period", period, 0);

    cur_code = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].strobe) exp_code_q.push_back(vecs[i].code);
      if (vecs[i].bad) exp_bad_q.push_back(16'(vecs[i].p));
      edge_after(int'(vecs[i].p));
      check_window($sformatf("vec%0d", i), cur_code, vecs[i].code,
                   vecs[i].bad, vecs[i].strobe, 16'(vecs[i].p));
      cur_code = vecs[i].code;
    end

    // Silence: no rising edge for TIMEOUT cycles after the last edge.
    wave_in = 1'b0;
    exp_code_q.push_back(4'd0);
    tick(int'(TIMEOUT_CYC) - 1);
    check("timeout_pre_code", tune_code, 14);
    check("timeout_pre_strobe", code_strobe, 0);
    tick(1);
    check("timeout_code", tune_code, 0);
    check("timeout_valid", code_valid, 0);
    check("timeout_strobe", code_strobe, 1);
    check("timeout_state", dbg_state, 0);

    // Restart needs a start edge plus two matching periods.
    tick(10);
    wave_in = 1'b1;
    tick(3);
    check("restart_state", dbg_state, 1);
    check("restart_period", period, 6818);
    edge_after(6818);
    check_window("restart1", 4'd0, 4'd0, 1'b0, 1'b0, 16'd6818);
    exp_code_q.push_back(4'd13);
    edge_after(6818);
    check_window("restart2", 4'd0, 4'd13, 1'b0, 1'b1, 16'd6818);

    // Enable low: IDLE within a cycle, outputs frozen, edges ignored.
    tick(100);
    en = 1'b0;
    tick(1);
    check("en_off_state", dbg_state, 0);
    check("en_off_code", tune_code, 13);
    check("en_off_valid", code_valid, 1);
    wave_in = 1'b0;
    tick(5);
    wave_in = 1'b1;
    tick(5);
    check("en_off_edge_state", dbg_state, 0);
    check("en_off_edge_period", period, 6818);
    en = 1'b1;
    wave_in = 1'b0;
    tick(10);
    wave_in = 1'b1;
    tick(2);
    check("en_on_pre_state", dbg_state, 0);
    tick(1);
    check("en_on_state", dbg_state, 1);
    check("en_on_period", period, 6818);
    check("en_on_code", tune_code, 13);

    // Reset mid-period clears everything at once.
    tick(40);
    nRST = 1'b0;
    #1;
    check("midrst_code", tune_code, 0);
    check("midrst_valid", code_valid, 0);
    check("midrst_strobe", code_strobe, 0);
    check("midrst_bad", bad_period, 0);
    check("midrst_period", period, 0);
    check("midrst_state", dbg_state, 0);
    wave_in = 1'b0;
    tick(3);
    nRST = 1'b1;
    tick(10);
    wave_in = 1'b1;
    tick(2);
    check("postrst_pre_state", dbg_state, 0);
    tick(1);
    check("postrst_state", dbg_state, 1);
    check("postrst_period", period, 0);
    exp_bad_q.push_back(16'd50);
    edge_after(50);
    check_window("short", 4'd0, 4'd0, 1'b1, 1'b0, 16'd50);

    tick(5);
    check("exp_code_q_empty", exp_code_q.size(), 0);
    check("exp_bad_q_empty", exp_bad_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
